// File: rtl/ctrl_buf_enq_arbiter.sv
// Round-robin enqueue arbiter for a shared ctrlBuf address FIFO. A shadow owner-tag FIFO
// runs in lockstep with the buffer so each dequeued entry is credited back to its producer.
module ctrl_buf_enq_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int BUFF_ENTRY_DWIDTH = 32,
  parameter int OUT_BUFF_SIZE     = 16,
  parameter int MAX_PER_REQ       = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req_en_mask,
  input  logic [NUM_REQ-1:0]                           req_valid,
  input  logic [NUM_REQ*BUFF_ENTRY_DWIDTH-1:0]         req_addr,
  output logic [NUM_REQ-1:0]                           req_ready,
  output logic                                         buf_enque_en,
  output logic [BUFF_ENTRY_DWIDTH-1:0]                 buf_addr,
  input  logic                                         buf_in_valid,
  input  logic                                         buf_deque_en,
  input  logic                                         buf_out_valid,
  output logic [$clog2(NUM_REQ)-1:0]                   deq_owner,
  output logic                                         deq_owner_vld,
  output logic [NUM_REQ*$clog2(MAX_PER_REQ+1)-1:0]     req_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_PER_REQ + 1);
  localparam int PTR_W = $clog2(OUT_BUFF_SIZE);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];
  logic [IDX_W-1:0] shadow_q [OUT_BUFF_SIZE];

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] inc_vec;
  logic [NUM_REQ-1:0] dec_vec;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   head_owner;
  logic               grant_found;
  logic               can_grant;
  logic               push;
  logic               pop;
  logic               empty;
  logic               full;

  // Shadow FIFO status uses the same one-slot-open rule as the attached buffer.
  assign empty      = (head_q == tail_q);
  assign full       = ((tail_q + 1'b1) == head_q);
  assign head_owner = shadow_q[head_q];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & req_en_mask[i] & (cnt_q[i] < CNT_W'(MAX_PER_REQ));
    end
  end

  // Round-robin scan starting at rr_ptr_q; first eligible index wins.
  always_comb begin
    int unsigned idx;
    // NOTE: every variable gets a default before the loop so no path can infer a latch.
    idx         = 0;
    grant_found = 1'b0;
    winner      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_found && elig[idx]) begin
        grant_found = 1'b1;
        winner      = IDX_W'(idx);
      end
    end
  end

  assign can_grant = !rst && buf_in_valid && !full;
  assign push      = grant_found && can_grant;
  // An illegal pop while empty is dropped so state stays consistent.
  assign pop       = buf_deque_en && buf_out_valid && !empty;

  assign req_ready     = push ? (NUM_REQ'(1) << winner) : '0;
  assign buf_enque_en  = push;
  assign buf_addr      = push ? req_addr[winner*BUFF_ENTRY_DWIDTH +: BUFF_ENTRY_DWIDTH]
                              : '0;
  assign deq_owner_vld = !empty;
  assign deq_owner     = empty ? '0 : head_owner;

  assign inc_vec = req_ready;
  assign dec_vec = pop ? (NUM_REQ'(1) << head_owner) : '0;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    tail_d   = tail_q;
    head_d   = head_q;
    if (push) begin
      rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      tail_d   = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
  end

  // NOTE: registers update with non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // NOTE: tag storage has no reset; deq_owner is masked while empty, so stale tags never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      shadow_q[tail_q] <= winner;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_count_out
    assign req_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  pop_when_empty_a : assert property (
    @(posedge clk) disable iff (rst) !(buf_deque_en && buf_out_valid && empty)
  );

endmodule

// File: tb/tb_ctrl_buf_enq_arbiter.sv
// Self-checking bench for ctrl_buf_enq_arbiter: directed scenarios plus a randomized run
// against a queue-based model of buffer contents, quotas and round-robin order.
module tb_ctrl_buf_enq_arbiter;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int MAXQ  = 8;
  localparam int CW    = 4;
  localparam int IW    = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_en_mask;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic            buf_enque_en;
  logic [DW-1:0]   buf_addr;
  logic            buf_in_valid;
  logic            buf_deque_en;
  logic            buf_out_valid;
  logic [IW-1:0]   deq_owner;
  logic            deq_owner_vld;
  logic [N*CW-1:0] req_count;

  ctrl_buf_enq_arbiter #(
    .NUM_REQ(N), .BUFF_ENTRY_DWIDTH(DW), .OUT_BUFF_SIZE(DEPTH), .MAX_PER_REQ(MAXQ)
  ) dut (
    .clk(clk), .rst(rst), .req_en_mask(req_en_mask), .req_valid(req_valid),
    .req_addr(req_addr), .req_ready(req_ready), .buf_enque_en(buf_enque_en),
    .buf_addr(buf_addr), .buf_in_valid(buf_in_valid), .buf_deque_en(buf_deque_en),
    .buf_out_valid(buf_out_valid), .deq_owner(deq_owner), .deq_owner_vld(deq_owner_vld),
    .req_count(req_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: buffer contents as a queue of owners, per-owner counts, rr pointer.
  int            owner_q[$];
  int            cnt[N];
  int            rr;
  int            exp_w;
  logic [N-1:0]  exp_ready;
  logic [DW-1:0] exp_addr;

  function automatic int model_winner();
    if (!buf_in_valid || owner_q.size() >= DEPTH - 1) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (rr + k) % N;
      if (req_valid[idx] && req_en_mask[idx] && cnt[idx] < MAXQ) return idx;
    end
    return -1;
  endfunction

  function automatic int dut_cnt(input int i);
    return int'(req_count[i*CW +: CW]);
  endfunction

  task automatic model_reset();
    owner_q.delete();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    rr = 0;
  endtask

  // Drive one cycle's inputs just after the falling edge and compute expectations.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] m, input bit deq,
                       input bit inv);
    req_valid     = v;
    req_en_mask   = m;
    buf_in_valid  = inv;
    buf_deque_en  = deq;
    buf_out_valid = (owner_q.size() > 0);
    for (int i = 0; i < N; i++) req_addr[i*DW +: DW] = $urandom;
    exp_w     = model_winner();
    exp_ready = (exp_w >= 0) ? N'(1 << exp_w) : '0;
    exp_addr  = (exp_w >= 0) ? req_addr[exp_w*DW +: DW] : '0;
    #1;
  endtask

  task automatic tick();
    int o;
    @(posedge clk);
    if (buf_deque_en && buf_out_valid) begin
      o = owner_q.pop_front();
      cnt[o]--;
    end
    if (exp_w >= 0) begin
      owner_q.push_back(exp_w);
      cnt[exp_w]++;
      rr = (exp_w + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    req_en_mask  = '0;
    buf_in_valid = 1'b0;
    buf_deque_en = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    req_valid = '1; req_en_mask = '1; buf_in_valid = 1'b1; buf_deque_en = 1'b0;
    buf_out_valid = 1'b0; req_addr = '0;
    #1;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset.ready_in_rst got=%b exp=0000", req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    drive('0, '1, 1'b0, 1'b1);
    n_tests++;
    if (req_ready !== '0 || buf_enque_en !== 1'b0) begin
      n_fail++; $display("FAIL reset.idle ready=%b enq=%b exp 0", req_ready, buf_enque_en);
    end
    n_tests++;
    if (deq_owner_vld !== 1'b0 || deq_owner !== '0) begin
      n_fail++; $display("FAIL reset.owner vld=%b owner=%0d exp 0", deq_owner_vld, deq_owner);
    end
    n_tests++;
    if (req_count !== '0) begin
      n_fail++; $display("FAIL reset.counts got=%h exp=0", req_count);
    end
    tick();
  endtask

  task automatic test_all_valid();
    logic [N-1:0] want;
    do_reset();
    for (int c = 0; c < 17; c++) begin
      drive('1, '1, 1'b0, 1'b1);
      want = (c < 15) ? N'(1 << (c % N)) : '0;
      n_tests++;
      if (req_ready !== want || buf_enque_en !== (want != 0)) begin
        n_fail++; $display("FAIL all_valid.grant c=%0d got=%b exp=%b", c, req_ready, want);
      end
      n_tests++;
      if (buf_addr !== exp_addr) begin
        n_fail++; $display("FAIL all_valid.addr c=%0d got=%h exp=%h", c, buf_addr, exp_addr);
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (dut_cnt(i) != ((i < 3) ? 4 : 3)) begin
        n_fail++; $display("FAIL all_valid.count[%0d] got=%0d exp=%0d", i, dut_cnt(i),
                           (i < 3) ? 4 : 3);
      end
    end
  endtask

  task automatic test_quota();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      drive(4'b0100, '1, 1'b0, 1'b1);
      n_tests++;
      if (req_ready !== ((c < MAXQ) ? 4'b0100 : 4'b0000)) begin
        n_fail++; $display("FAIL quota.grant c=%0d got=%b", c, req_ready);
      end
      tick();
    end
    n_tests++;
    if (dut_cnt(2) != MAXQ) begin
      n_fail++; $display("FAIL quota.full_count got=%0d exp=%0d", dut_cnt(2), MAXQ);
    end
    drive(4'b0100, '1, 1'b1, 1'b1);
    n_tests++;
    if (req_ready !== 4'b0000 || deq_owner !== 2'd2) begin
      n_fail++; $display("FAIL quota.pop_cycle ready=%b owner=%0d exp 0000/2", req_ready, deq_owner);
    end
    tick();
    n_tests++;
    if (dut_cnt(2) != 7) begin
      n_fail++; $display("FAIL quota.after_pop got=%0d exp=7", dut_cnt(2));
    end
    drive(4'b0100, '1, 1'b0, 1'b1);
    n_tests++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL quota.resume got=%b exp=0100", req_ready);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int c = 0; c < 3; c++) begin drive(4'b0010, '1, 1'b0, 1'b1); tick(); end
    drive(4'b0010, '1, 1'b1, 1'b1);
    n_tests++;
    if (req_ready !== 4'b0010 || deq_owner !== 2'd1) begin
      n_fail++; $display("FAIL simul.same ready=%b owner=%0d exp 0010/1", req_ready, deq_owner);
    end
    tick();
    n_tests++;
    if (dut_cnt(1) != 3) begin
      n_fail++; $display("FAIL simul.same_count got=%0d exp=3", dut_cnt(1));
    end
    do_reset();
    for (int c = 0; c < 2; c++) begin drive(4'b1000, '1, 1'b0, 1'b1); tick(); end
    drive(4'b0001, '1, 1'b1, 1'b1);
    n_tests++;
    if (req_ready !== 4'b0001 || deq_owner !== 2'd3) begin
      n_fail++; $display("FAIL simul.diff ready=%b owner=%0d exp 0001/3", req_ready, deq_owner);
    end
    tick();
    n_tests++;
    if (dut_cnt(0) != 1 || dut_cnt(3) != 1) begin
      n_fail++; $display("FAIL simul.diff_count c0=%0d c3=%0d exp 1/1", dut_cnt(0), dut_cnt(3));
    end
  endtask

  task automatic drain_and_check(input string tag);
    int guard;
    guard = 0;
    while (owner_q.size() > 0 && guard < 40) begin
      drive('0, '1, 1'b1, 1'b1);
      n_tests++;
      if (deq_owner_vld !== 1'b1 || int'(deq_owner) != owner_q[0]) begin
        n_fail++; $display("FAIL %s.owner vld=%b got=%0d exp=%0d", tag, deq_owner_vld,
                           deq_owner, owner_q[0]);
      end
      tick();
      guard++;
    end
    drive('0, '1, 1'b0, 1'b1);
    n_tests++;
    if (deq_owner_vld !== 1'b0 || req_count !== '0) begin
      n_fail++; $display("FAIL %s.empty vld=%b counts=%h exp 0/0", tag, deq_owner_vld, req_count);
    end
  endtask

  task automatic test_wrap();
    int guard;
    do_reset();
    for (int c = 0; c < 15; c++) begin drive('1, '1, 1'b0, 1'b1); tick(); end
    drain_and_check("wrap1");
    guard = 0;
    while (owner_q.size() < DEPTH - 1 && guard < 80) begin
      drive(N'($urandom_range(1, 15)), '1, 1'b0, 1'b1);
      n_tests++;
      if (req_ready !== exp_ready) begin
        n_fail++; $display("FAIL wrap.refill got=%b exp=%b", req_ready, exp_ready);
      end
      tick();
      guard++;
    end
    drive('1, '1, 1'b0, 1'b1);
    n_tests++;
    if (req_ready !== exp_ready || deq_owner_vld !== 1'b1) begin
      n_fail++; $display("FAIL wrap.full ready=%b exp=%b vld=%b", req_ready, exp_ready, deq_owner_vld);
    end
    drain_and_check("wrap2");
  endtask

  task automatic test_random();
    int pop_mod;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pop_mod = (c < 200) ? 3 : 2;
      drive(N'($urandom), N'($urandom | $urandom), (($urandom % 3) < pop_mod - 1),
            (($urandom % 8) != 0));
      n_tests++;
      if (req_ready !== exp_ready || buf_enque_en !== (exp_w >= 0) || buf_addr !== exp_addr) begin
        n_fail++; $display("FAIL random.grant c=%0d ready=%b/%b addr=%h/%h", c, req_ready,
                           exp_ready, buf_addr, exp_addr);
      end
      n_tests++;
      if (deq_owner_vld !== (owner_q.size() > 0) ||
          int'(deq_owner) != ((owner_q.size() > 0) ? owner_q[0] : 0)) begin
        n_fail++; $display("FAIL random.owner c=%0d vld=%b owner=%0d", c, deq_owner_vld, deq_owner);
      end
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (dut_cnt(i) != cnt[i]) begin
          n_fail++; $display("FAIL random.count[%0d] c=%0d got=%0d exp=%0d", i, c, dut_cnt(i), cnt[i]);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 6; c++) begin drive('1, '1, 1'b0, 1'b1); tick(); end
    drive('1, '1, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (deq_owner_vld !== 1'b0 || req_count !== '0 || req_ready !== '0) begin
      n_fail++; $display("FAIL reset_mid.clear vld=%b counts=%h ready=%b exp 0", deq_owner_vld,
                         req_count, req_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(4'b1010, '1, 1'b0, 1'b1);
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL reset_mid.first_grant got=%b exp=0010", req_ready);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_en_mask = '0; req_addr = '0;
    buf_in_valid = 1'b0; buf_deque_en = 1'b0; buf_out_valid = 1'b0;
    test_reset();
    test_all_valid();
    test_quota();
    test_simultaneous();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
